dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single data memory between two requesters: port 0 (core load/store path) and port 1 (program loader / debug port).
- Sits between the requesters and the data memory.
- Sequences each access: command issue, a fixed read-latency wait and a registered response.
- Arbitrates fairly with round-robin, and provides a hold input that lets the loader lock the core out while it initialises memory.

Parameters:
ADDR_WIDTH, 32, width of request/memory address
DATA_WIDTH, 32, width of read/write data
MEM_LATENCY, 1, cycles from read issue until memory read data is valid (legal range 1..7)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
p0_req_valid  input  1  core request pending
p0_req_write  input  1  1 = store, 0 = load
p0_req_addr  input  ADDR_WIDTH  core access address
p0_req_wdata  input  DATA_WIDTH  core store data
p0_req_ready  output  1  core request accepted this cycle
p0_rsp_valid  output  1  core load data valid (1-cycle pulse)
p0_rsp_rdata  output  DATA_WIDTH  core load data
p1_req_valid  input  1  loader request pending
p1_req_write  input  1  1 = store, 0 = load
p1_req_addr  input  ADDR_WIDTH  loader access address
p1_req_wdata  input  DATA_WIDTH  loader store data
p1_req_ready  output  1  loader request accepted this cycle
p1_rsp_valid  output  1  loader load data valid (1-cycle pulse)
p1_rsp_rdata  output  DATA_WIDTH  loader load data
p1_hold  input  1  while high, port 0 is never granted
core_stall  output  1  p0_req_valid & ~p0_req_ready
mem_read_enable  output  1  memory read strobe
mem_write_enable  output  1  memory write strobe
mem_address  output  ADDR_WIDTH  memory address
mem_write_data  output  DATA_WIDTH  memory write data
mem_read_data  input  DATA_WIDTH  memory read data

Behaviour:
- Reset values:
  - state = IDLE, wait counter = 0, last_grant = 1 (port 0 has first priority).
  - All ready, rsp_valid and mem enables are 0; rsp_rdata = 0.
  - Reset takes effect on the next rising edge.
- Handshake:
  - A request transfers in any cycle where req_valid & req_ready.
  - Requesters hold valid, write, addr and wdata stable until accepted.
  - req_ready is combinational from state, the valids, p1_hold and last_grant.
  - At most one ready is high per cycle.
- State IDLE, winner selection:
  - Only one eligible valid: that port wins. Port 0 is ineligible while p1_hold = 1.
  - Both eligible: the port not equal to last_grant wins.
  - Winner gets ready = 1 in the same cycle. mem_address, mem_write_data and mem_write_enable (store) or mem_read_enable (load) are driven combinationally from the winner that cycle; last_grant updates to the winner.
  - Store: completes in the issue cycle, no response, and state stays IDLE. Back-to-back stores sustain 1 per cycle.
  - Load: state goes to READ_WAIT; counter loads MEM_LATENCY; the owner port is latched.
- State READ_WAIT:
  - All ready and mem enables are 0; the counter decrements each cycle.
  - A load issued in cycle T has memory data valid in cycle T+MEM_LATENCY. The arbiter registers mem_read_data at the end of that cycle.
  - The owner's rsp_valid = 1 with rsp_rdata in cycle T+MEM_LATENCY+1, for exactly one cycle. The state is IDLE in that same cycle, so a new grant can occur alongside the response pulse.
  - Load throughput: 1 per MEM_LATENCY+1 cycles.
- rsp_rdata holds its last value when rsp_valid = 0.
- The non-owner rsp_valid stays 0.
- p1_hold changing during READ_WAIT does not affect the in-flight load.
- Reset during READ_WAIT: the load is dropped, no rsp_valid is generated, and memory enables are 0 from the following cycle.
- Neither valid in IDLE: memory enables are 0, mem_address and mem_write_data are 0.
- Addresses are passed through unmodified; alignment is the memory's responsibility.

Test Plan:
- Reset, then p0 load 0x0000_0010 with MEM_LATENCY=1 and mem_read_data=0xDEAD_BEEF in cycle T+1 -> p0_req_ready=1 and mem_read_enable=1 in T; p0_rsp_valid=1 with rdata=0xDEAD_BEEF in T+2 only; core_stall=0 in T.
- Both ports request stores every cycle for 4 cycles -> grants alternate p0, p1, p0, p1; the non-granted port sees ready=0 each cycle, and core_stall=1 on p1 cycles.
- p1_hold=1 with both requesting stores for 3 cycles -> p1 granted all 3 cycles; p0_req_ready=0 and core_stall=1 throughout. Release hold with both still requesting -> p0 granted next.
- MEM_LATENCY=3: p0 load in T with p1 load pending -> p1_req_ready=0 in T+1..T+3. p0_rsp_valid in T+4 and p1_req_ready=1 in the same cycle; p1_rsp_valid in T+8.
- Assert reset in T+1 of a p1 load (MEM_LATENCY=3) -> no p1_rsp_valid ever; state is IDLE; the next simultaneous request grants p0 first.
- p0 stores 0x1234_5678 to 0x40 -> mem_write_enable=1, mem_address=0x40, mem_write_data=0x1234_5678 in the issue cycle only; no rsp_valid follows.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Purpose: shares one data memory between the core port (p0) and the loader/debug port (p1), round-robin with a loader hold.
// Latency: stores issue and complete in the grant cycle; load data returns MEM_LATENCY+1 cycles after the grant as a 1-cycle pulse.
// Backpressure: req_ready is high for at most one port, only in IDLE; no grants while a load waits for memory data.
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  p0_req_valid,
  input  logic                  p0_req_write,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  input  logic [DATA_WIDTH-1:0] p0_req_wdata,
  output logic                  p0_req_ready,
  output logic                  p0_rsp_valid,
  output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
  input  logic                  p1_req_valid,
  input  logic                  p1_req_write,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  input  logic [DATA_WIDTH-1:0] p1_req_wdata,
  output logic                  p1_req_ready,
  output logic                  p1_rsp_valid,
  output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
  input  logic                  p1_hold,
  output logic                  core_stall,
  output logic                  mem_read_enable,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_READ_WAIT = 1'b1
  } state_t;

  // The wait counter starts at MEM_LATENCY and the response is captured when it reaches 1.
  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  last_grant_q, last_grant_d;   // 1 = port 1 was granted last
  logic                  owner_q, owner_d;             // port that owns the in-flight load
  logic                  p0_rsp_q, p0_rsp_d;
  logic                  p1_rsp_q, p1_rsp_d;
  logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_WIDTH-1:0] p1_rdata_q, p1_rdata_d;

  logic grant0;
  logic grant1;
  logic grant_load;

  // Winner selection: only in IDLE; p0 is ineligible under hold; ties go to the port not granted last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == ST_IDLE) begin
      if ((p0_req_valid && !p1_hold) && p1_req_valid) begin
        if (last_grant_q) grant0 = 1'b1;
        else              grant1 = 1'b1;
      end else if (p0_req_valid && !p1_hold) begin
        grant0 = 1'b1;
      end else if (p1_req_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  // Memory command driven straight from the winner in the grant cycle; idle bus is all zeros.
  always_comb begin
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_address      = '0;
    mem_write_data   = '0;
    if (grant0) begin
      mem_read_enable  = !p0_req_write;
      mem_write_enable = p0_req_write;
      mem_address      = p0_req_addr;
      mem_write_data   = p0_req_wdata;
    end else if (grant1) begin
      mem_read_enable  = !p1_req_write;
      mem_write_enable = p1_req_write;
      mem_address      = p1_req_addr;
      mem_write_data   = p1_req_wdata;
    end
  end

  assign grant_load   = (grant0 && !p0_req_write) || (grant1 && !p1_req_write);
  assign p0_req_ready = grant0;
  assign p1_req_ready = grant1;
  assign core_stall   = p0_req_valid && !grant0;
  assign p0_rsp_valid = p0_rsp_q;
  assign p1_rsp_valid = p1_rsp_q;
  assign p0_rsp_rdata = p0_rdata_q;
  assign p1_rsp_rdata = p1_rdata_q;

  // Sequencer next state: loads park in READ_WAIT until memory data is valid, then capture it for a 1-cycle response.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    p0_rsp_d     = 1'b0;
    p1_rsp_d     = 1'b0;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant0 || grant1) begin
          last_grant_d = grant1;
        end
        if (grant_load) begin
          state_d = ST_READ_WAIT;
          cnt_d   = LAT;
          owner_d = grant1;
        end
      end
      ST_READ_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = ST_IDLE;
          if (owner_q) begin
            p1_rsp_d   = 1'b1;
            p1_rdata_d = mem_read_data;
          end else begin
            p0_rsp_d   = 1'b1;
            p0_rdata_d = mem_read_data;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any in-flight load and gives port 0 first priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      p0_rsp_q     <= 1'b0;
      p1_rsp_q     <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      p0_rsp_q     <= p0_rsp_d;
      p1_rsp_q     <= p1_rsp_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Purpose: directed bench for dmem_port_arbiter with MEM_LATENCY=1 (index 0) and MEM_LATENCY=3 (index 1).
// Latency: inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Backpressure: requesters hold their request until they see ready at the falling-edge sample.
module tb_dmem_port_arbiter;

  typedef struct packed {
    logic        rst;
    logic        hold;
    logic        p0_vld;
    logic        p0_wr;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdat;
    logic        p1_vld;
    logic        p1_wr;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdat;
    logic [31:0] mrd;
  } din_t;

  typedef struct packed {
    logic        p0_rdy;
    logic        p0_rsp_vld;
    logic [31:0] p0_rsp_dat;
    logic        p1_rdy;
    logic        p1_rsp_vld;
    logic [31:0] p1_rsp_dat;
    logic        stall;
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdat;
  } dout_t;

  logic  clk = 1'b0;
  int    cyc = 0;
  int    tests = 0;
  int    fails = 0;
  din_t  din  [2];
  dout_t dout [2];

  logic        a_p0_rdy, a_p0_rsp_vld, a_p1_rdy, a_p1_rsp_vld, a_stall, a_re, a_we;
  logic [31:0] a_p0_rsp_dat, a_p1_rsp_dat, a_addr, a_wdat;
  logic        b_p0_rdy, b_p0_rsp_vld, b_p1_rdy, b_p1_rsp_vld, b_stall, b_re, b_we;
  logic [31:0] b_p0_rsp_dat, b_p1_rsp_dat, b_addr, b_wdat;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut_a (
    .clock(clk), .reset(din[0].rst),
    .p0_req_valid(din[0].p0_vld), .p0_req_write(din[0].p0_wr),
    .p0_req_addr(din[0].p0_addr), .p0_req_wdata(din[0].p0_wdat),
    .p0_req_ready(a_p0_rdy), .p0_rsp_valid(a_p0_rsp_vld), .p0_rsp_rdata(a_p0_rsp_dat),
    .p1_req_valid(din[0].p1_vld), .p1_req_write(din[0].p1_wr),
    .p1_req_addr(din[0].p1_addr), .p1_req_wdata(din[0].p1_wdat),
    .p1_req_ready(a_p1_rdy), .p1_rsp_valid(a_p1_rsp_vld), .p1_rsp_rdata(a_p1_rsp_dat),
    .p1_hold(din[0].hold), .core_stall(a_stall),
    .mem_read_enable(a_re), .mem_write_enable(a_we),
    .mem_address(a_addr), .mem_write_data(a_wdat), .mem_read_data(din[0].mrd)
  );

  dmem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3)) dut_b (
    .clock(clk), .reset(din[1].rst),
    .p0_req_valid(din[1].p0_vld), .p0_req_write(din[1].p0_wr),
    .p0_req_addr(din[1].p0_addr), .p0_req_wdata(din[1].p0_wdat),
    .p0_req_ready(b_p0_rdy), .p0_rsp_valid(b_p0_rsp_vld), .p0_rsp_rdata(b_p0_rsp_dat),
    .p1_req_valid(din[1].p1_vld), .p1_req_write(din[1].p1_wr),
    .p1_req_addr(din[1].p1_addr), .p1_req_wdata(din[1].p1_wdat),
    .p1_req_ready(b_p1_rdy), .p1_rsp_valid(b_p1_rsp_vld), .p1_rsp_rdata(b_p1_rsp_dat),
    .p1_hold(din[1].hold), .core_stall(b_stall),
    .mem_read_enable(b_re), .mem_write_enable(b_we),
    .mem_address(b_addr), .mem_write_data(b_wdat), .mem_read_data(din[1].mrd)
  );

  // Gather both DUTs' outputs into one indexable view.
  always_comb begin
    dout[0] = '{a_p0_rdy, a_p0_rsp_vld, a_p0_rsp_dat, a_p1_rdy, a_p1_rsp_vld, a_p1_rsp_dat,
                a_stall, a_re, a_we, a_addr, a_wdat};
    dout[1] = '{b_p0_rdy, b_p0_rsp_vld, b_p0_rsp_dat, b_p1_rdy, b_p1_rsp_vld, b_p1_rsp_dat,
                b_stall, b_re, b_we, b_addr, b_wdat};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model: timestamps instead of state ----------------
  int          free_at [2];     // first cycle a new grant is allowed
  int          iss     [2];     // issue cycle of the outstanding load
  bit          pend    [2];
  bit          powner  [2];
  bit          last    [2];     // 1 = port 1 granted last
  bit          chk_en  [2];
  logic [31:0] mdat    [2][2];  // last response data per DUT, per port

  int          m_lat, m_win;
  logic        m_e0, m_e1, m_wr, m_rsp0, m_rsp1;
  logic [31:0] m_addr, m_wdat;
  din_t        m_x;

  initial begin
    for (int d = 0; d < 2; d++) begin
      free_at[d] = 0; iss[d] = 0; pend[d] = 0; powner[d] = 0; last[d] = 1; chk_en[d] = 0;
      mdat[d][0] = '0; mdat[d][1] = '0;
    end
  end

  // Compare every output of both DUTs against the model each cycle, then advance the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      m_x   = din[d];
      m_lat = (d == 0) ? 1 : 3;
      m_e0  = m_x.p0_vld && !m_x.hold;
      m_e1  = m_x.p1_vld;
      m_win = -1;
      if (cyc >= free_at[d]) begin
        if (m_e0 && m_e1) m_win = last[d] ? 0 : 1;
        else if (m_e0)    m_win = 0;
        else if (m_e1)    m_win = 1;
      end
      m_wr   = (m_win == 0) ? m_x.p0_wr   : m_x.p1_wr;
      m_addr = (m_win == 0) ? m_x.p0_addr : (m_win == 1) ? m_x.p1_addr : 32'h0;
      m_wdat = (m_win == 0) ? m_x.p0_wdat : (m_win == 1) ? m_x.p1_wdat : 32'h0;
      m_rsp0 = pend[d] && (cyc == iss[d] + m_lat + 1) && !powner[d];
      m_rsp1 = pend[d] && (cyc == iss[d] + m_lat + 1) &&  powner[d];
      if (chk_en[d]) begin
        chk($sformatf("d%0d p0_req_ready", d), 32'(dout[d].p0_rdy), 32'(m_win == 0));
        chk($sformatf("d%0d p1_req_ready", d), 32'(dout[d].p1_rdy), 32'(m_win == 1));
        chk($sformatf("d%0d core_stall", d),   32'(dout[d].stall),  32'(m_x.p0_vld && m_win != 0));
        chk($sformatf("d%0d mem_read_enable", d),  32'(dout[d].re), 32'(m_win >= 0 && !m_wr));
        chk($sformatf("d%0d mem_write_enable", d), 32'(dout[d].we), 32'(m_win >= 0 && m_wr));
        chk($sformatf("d%0d mem_address", d),    dout[d].addr, m_addr);
        chk($sformatf("d%0d mem_write_data", d), dout[d].wdat, m_wdat);
        chk($sformatf("d%0d p0_rsp_valid", d), 32'(dout[d].p0_rsp_vld), 32'(m_rsp0));
        chk($sformatf("d%0d p1_rsp_valid", d), 32'(dout[d].p1_rsp_vld), 32'(m_rsp1));
        chk($sformatf("d%0d p0_rsp_rdata", d), dout[d].p0_rsp_dat, mdat[d][0]);
        chk($sformatf("d%0d p1_rsp_rdata", d), dout[d].p1_rsp_dat, mdat[d][1]);
      end
      if (m_x.rst) begin
        free_at[d] = cyc + 1; pend[d] = 0; last[d] = 1; chk_en[d] = 1;
        mdat[d][0] = '0; mdat[d][1] = '0;
      end else begin
        if (pend[d] && cyc == iss[d] + m_lat) mdat[d][powner[d]] = m_x.mrd;
        if (pend[d] && cyc == iss[d] + m_lat + 1) pend[d] = 0;
        if (m_win >= 0) begin
          last[d] = (m_win == 1);
          if (!m_wr) begin
            pend[d] = 1; iss[d] = cyc; powner[d] = (m_win == 1); free_at[d] = cyc + m_lat + 1;
          end
        end
      end
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    din[0].mrd = 32'hC0DE_0000 ^ 32'(cyc);
    din[1].mrd = 32'h5EED_0000 ^ 32'(cyc);
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    din[0] = '0;
    din[1] = '0;
    din[0].rst = 1'b1;
    din[1].rst = 1'b1;
    tick(); smp();
    chk("rst p0_rsp_valid", 32'(dout[0].p0_rsp_vld), 32'h0);
    chk("rst p0_rsp_rdata", dout[0].p0_rsp_dat, 32'h0);
    chk("rst mem_enables",  32'({dout[1].re, dout[1].we}), 32'h0);
    tick(); din[0].rst = 1'b0; din[1].rst = 1'b0;

    // MEM_LATENCY=1 p0 load
    tick(); din[0].p0_vld = 1; din[0].p0_wr = 0; din[0].p0_addr = 32'h0000_0010;
    smp();
    chk("ld1 p0_req_ready T", 32'(dout[0].p0_rdy), 32'h1);
    chk("ld1 mem_read_enable T", 32'(dout[0].re), 32'h1);
    chk("ld1 mem_address T", dout[0].addr, 32'h0000_0010);
    chk("ld1 core_stall T", 32'(dout[0].stall), 32'h0);
    tick(); din[0].p0_vld = 0; din[0].mrd = 32'hDEAD_BEEF;
    smp(); chk("ld1 p0_rsp_valid T+1", 32'(dout[0].p0_rsp_vld), 32'h0);
    tick(); smp();
    chk("ld1 p0_rsp_valid T+2", 32'(dout[0].p0_rsp_vld), 32'h1);
    chk("ld1 p0_rsp_rdata T+2", dout[0].p0_rsp_dat, 32'hDEAD_BEEF);
    tick(); smp();
    chk("ld1 p0_rsp_valid T+3", 32'(dout[0].p0_rsp_vld), 32'h0);
    chk("ld1 p0_rsp_rdata hold", dout[0].p0_rsp_dat, 32'hDEAD_BEEF);

    // Round-robin stores after a fresh reset
    tick(); din[0].rst = 1;
    tick(); din[0].rst = 0;
    din[0].p0_vld = 1; din[0].p0_wr = 1; din[0].p0_addr = 32'h100; din[0].p0_wdat = 32'hA0A0_A0A0;
    din[0].p1_vld = 1; din[0].p1_wr = 1; din[0].p1_addr = 32'h200; din[0].p1_wdat = 32'hB1B1_B1B1;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk($sformatf("rr%0d p0_req_ready", k), 32'(dout[0].p0_rdy), 32'(k % 2 == 0));
      chk($sformatf("rr%0d p1_req_ready", k), 32'(dout[0].p1_rdy), 32'(k % 2 == 1));
      chk($sformatf("rr%0d core_stall", k),   32'(dout[0].stall),  32'(k % 2 == 1));
      chk($sformatf("rr%0d mem_address", k),  dout[0].addr, (k % 2 == 0) ? 32'h100 : 32'h200);
      tick();
    end

    // Loader hold locks the core out
    din[0].hold = 1;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk($sformatf("hold%0d p1_req_ready", k), 32'(dout[0].p1_rdy), 32'h1);
      chk($sformatf("hold%0d p0_req_ready", k), 32'(dout[0].p0_rdy), 32'h0);
      chk($sformatf("hold%0d core_stall", k),   32'(dout[0].stall),  32'h1);
      tick();
    end
    din[0].hold = 0;
    smp();
    chk("unhold p0_req_ready", 32'(dout[0].p0_rdy), 32'h1);
    chk("unhold p1_req_ready", 32'(dout[0].p1_rdy), 32'h0);

    // Single p0 store
    tick(); din[0].p1_vld = 0; din[0].p0_addr = 32'h40; din[0].p0_wdat = 32'h1234_5678;
    smp();
    chk("st mem_write_enable", 32'(dout[0].we), 32'h1);
    chk("st mem_address", dout[0].addr, 32'h40);
    chk("st mem_write_data", dout[0].wdat, 32'h1234_5678);
    tick(); din[0].p0_vld = 0;
    smp(); chk("st mem_write_enable after", 32'(dout[0].we), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick(); smp();
      chk($sformatf("st norsp%0d", k), 32'({dout[0].p0_rsp_vld, dout[0].p1_rsp_vld}), 32'h0);
    end

    // MEM_LATENCY=3: p0 load with p1 load pending
    tick();
    din[1].p0_vld = 1; din[1].p0_wr = 0; din[1].p0_addr = 32'h20;
    din[1].p1_vld = 1; din[1].p1_wr = 0; din[1].p1_addr = 32'h30;
    smp();
    chk("ld3 p0_req_ready T", 32'(dout[1].p0_rdy), 32'h1);
    chk("ld3 p1_req_ready T", 32'(dout[1].p1_rdy), 32'h0);
    tick(); din[1].p0_vld = 0;
    smp(); chk("ld3 p1_req_ready T+1", 32'(dout[1].p1_rdy), 32'h0);
    tick(); smp(); chk("ld3 p1_req_ready T+2", 32'(dout[1].p1_rdy), 32'h0);
    tick(); din[1].mrd = 32'hAAAA_0001;
    smp(); chk("ld3 p1_req_ready T+3", 32'(dout[1].p1_rdy), 32'h0);
    tick(); smp();
    chk("ld3 p0_rsp_valid T+4", 32'(dout[1].p0_rsp_vld), 32'h1);
    chk("ld3 p0_rsp_rdata T+4", dout[1].p0_rsp_dat, 32'hAAAA_0001);
    chk("ld3 p1_req_ready T+4", 32'(dout[1].p1_rdy), 32'h1);
    tick(); din[1].p1_vld = 0;
    tick();
    tick(); din[1].mrd = 32'hBBBB_0002;
    smp(); chk("ld3 p1_rsp_valid T+7", 32'(dout[1].p1_rsp_vld), 32'h0);
    tick(); smp();
    chk("ld3 p1_rsp_valid T+8", 32'(dout[1].p1_rsp_vld), 32'h1);
    chk("ld3 p1_rsp_rdata T+8", dout[1].p1_rsp_dat, 32'hBBBB_0002);

    // Reset during an in-flight p1 load
    tick(); din[1].p1_vld = 1; din[1].p1_wr = 0; din[1].p1_addr = 32'h50;
    smp(); chk("rstld p1_req_ready T", 32'(dout[1].p1_rdy), 32'h1);
    tick(); din[1].p1_vld = 0; din[1].rst = 1;
    tick(); din[1].rst = 0;
    smp(); chk("rstld mem_read_enable", 32'(dout[1].re), 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick(); smp();
      chk($sformatf("rstld no p1_rsp %0d", k), 32'(dout[1].p1_rsp_vld), 32'h0);
    end
    tick();
    din[1].p0_vld = 1; din[1].p0_wr = 1; din[1].p0_addr = 32'h60;
    din[1].p1_vld = 1; din[1].p1_wr = 1; din[1].p1_addr = 32'h70;
    smp();
    chk("rstld p0 first", 32'(dout[1].p0_rdy), 32'h1);
    chk("rstld p1 waits", 32'(dout[1].p1_rdy), 32'h0);
    tick(); din[1].p0_vld = 0; din[1].p1_vld = 0;
    tick(); tick(); smp();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
